// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store narrowing path.
// Contents: FSM state encoding, request size encodings, memory port width,
// high-beat address offset, and an alignment helper.
package store_narrow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam logic SIZE_HALF = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int MEM_W          = 16;
    localparam int HI_BEAT_OFFSET = 2;

    // Half stores need a 2-byte boundary, word stores need a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb,
                                           input logic       size);
        return addr_lsb[0] | ((size == SIZE_WORD) & addr_lsb[1]);
    endfunction

endpackage

// File: rtl/sign_fit_check.sv
// Combinational check: does a 32-bit value survive a round trip through
// 16-bit storage followed by the load path's 16->32 sign extension?
// Ports:
//   data_i   - 32-bit register value
//   fits16_o - 1 when data_i[31:16] is a copy of data_i[15]
// Instantiated by store_narrow_unit only when TRUNC_CHECK_EN is defined.
module sign_fit_check
    import store_narrow_pkg::*;
(
    input  logic [2*MEM_W-1:0] data_i,
    output logic               fits16_o
);

    assign fits16_o = (data_i[2*MEM_W-1:MEM_W] == {MEM_W{data_i[MEM_W-1]}});

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: writes a 32-bit register value to a 16-bit data
// memory. Half stores issue one beat, word stores two little-endian beats
// (low half at addr, high half at addr+2), each held until mem_ack.
// Misaligned requests write nothing and finish with err.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake (ready only in IDLE)
//   req_addr/req_data/req_size- byte address, store value, 0=half 1=word
//   mem_we/mem_addr/mem_wdata - memory write beat, held until mem_ack
//   mem_ack                   - memory accepted the current beat
//   done, err                 - one-cycle completion pulse, misalignment flag
//   trunc_err                 - (TRUNC_CHECK_EN only) half store value was
//                               not representable as sign-extended 16 bits
// Optional feature macro: TRUNC_CHECK_EN.
// All outputs are registers; nothing combinational reaches them from inputs.
module store_narrow_unit
    import store_narrow_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [MEM_W-1:0]  mem_wdata,
    input  logic              mem_ack,
`ifdef TRUNC_CHECK_EN
    output logic              trunc_err,
`endif
    output logic              done,
    output logic              err
);

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic               size_q;
    logic               err_flag_q;
    logic               req_ready_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [MEM_W-1:0]   mem_wdata_q;
    logic               done_q;

`ifdef TRUNC_CHECK_EN
    logic fits16;
    logic trunc_err_q;

    sign_fit_check u_sign_fit_check (
        .data_i   (data_q),
        .fits16_o (fits16)
    );

    assign trunc_err = trunc_err_q;
`endif

    // Outputs are registered for the state being entered, so each one is
    // already valid in the first cycle of its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= SIZE_HALF;
            err_flag_q  <= 1'b0;
            req_ready_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
`ifdef TRUNC_CHECK_EN
            trunc_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        data_q      <= req_data;
                        size_q      <= req_size;
                        req_ready_q <= 1'b0;
                        if (is_misaligned(req_addr[1:0], req_size)) begin
                            state_q    <= FIN;
                            err_flag_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            state_q     <= WR_LO;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_data[MEM_W-1:0];
                        end
                    end
                end

                WR_LO: begin
                    if (mem_ack) begin
                        if (size_q == SIZE_WORD) begin
                            state_q     <= WR_HI;
                            // Address wrap-around at the top of the space is intended.
                            mem_addr_q  <= addr_q + ADDR_W'(HI_BEAT_OFFSET);
                            mem_wdata_q <= data_q[DATA_W-1:MEM_W];
                        end else begin
                            state_q     <= FIN;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_wdata_q <= '0;
                            done_q      <= 1'b1;
`ifdef TRUNC_CHECK_EN
                            trunc_err_q <= ~fits16;
`endif
                        end
                    end
                end

                WR_HI: begin
                    if (mem_ack) begin
                        state_q     <= FIN;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                    end
                end

                FIN: begin
                    state_q     <= IDLE;
                    err_flag_q  <= 1'b0;
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
`ifdef TRUNC_CHECK_EN
                    trunc_err_q <= 1'b0;
`endif
                end

                default: begin
                    state_q     <= IDLE;
                    err_flag_q  <= 1'b0;
                    done_q      <= 1'b0;
                    mem_we_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_flag_q;

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
Store-side counterpart of the load path's 16→32 sign extension. It takes a 32-bit register value plus a size and narrows it onto the 16-bit data-memory write port. Half stores take one beat; word stores take two little-endian beats, with a memory ack handshake per beat. It sits between the execute/mem pipeline stage and the 16-bit data memory.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, register/store-data width; fixed at 2*MEM_W.
MEM_W, 16, memory data port width.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  store request present.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_addr  in  ADDR_W  byte address.
req_data  in  DATA_W  register value to store.
req_size  in  1  0 = half (16 b), 1 = word (32 b).
mem_we  out  1  memory write strobe; held until mem_ack.
mem_addr  out  ADDR_W  beat address.
mem_wdata  out  MEM_W  beat data.
mem_ack  in  1  memory accepted the current beat.
done  out  1  one-cycle pulse: request finished.
err  out  1  one-cycle pulse with done: misaligned request, nothing written.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0. Latched addr/data/size are cleared to 0.
- States: IDLE, WR_LO, WR_HI, FIN.
- IDLE: req_ready=1. On req_valid, latch addr, data and size. Alignment is checked on the latched values:
  - half requires addr[0]=0;
  - word requires addr[1:0]=0;
  - aligned request -> WR_LO;
  - misaligned request -> FIN with error flag set.
- WR_LO:
  - mem_we=1, mem_addr=addr, mem_wdata=data[15:0].
  - On mem_ack: word -> WR_HI; half -> FIN.
  - Without ack: stay, with all outputs stable.
- WR_HI:
  - mem_we=1, mem_addr=addr+2 (ADDR_W wrap-around permitted), mem_wdata=data[31:16].
  - On mem_ack -> FIN.
- FIN:
  - done=1, err=error flag, mem_we=0, req_ready=0.
  - Next state is IDLE and the error flag clears.
- Outputs are Moore, decoded from the state register and latched data only. No combinational path from req_* or mem_ack to any output.
- Latency with mem_ack tied high:
  - accept at edge 0;
  - half: we in cycle 1, done in cycle 2;
  - word: we in cycles 1–2, done in cycle 3;
  - misaligned: done+err in cycle 1.
  - Each cycle of ack stall adds one cycle.
- Throughput: next request is accepted in the cycle after FIN.
- Boundaries:
  - mem_ack outside WR_LO/WR_HI is ignored.
  - req_valid while not in IDLE is ignored; the requester must hold it.
  - rst in any state returns to IDLE on that edge. mem_we drops and no done is issued; a partially written word is not completed.
  - rst and req_valid in the same cycle: reset wins.

Optional Feature:
TRUNC_CHECK_EN
- Defined:
  - adds output trunc_err (1 b), reset 0;
  - pulses in FIN for an aligned half store when data[31:16] != {16{data[15]}}, i.e. the value is not representable as sign-extended 16 bits;
  - the store is still performed;
  - always 0 for word stores and misaligned requests.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package store_narrow_pkg holds:
  - the state enum (IDLE, WR_LO, WR_HI, FIN);
  - size encodings SIZE_HALF=1'b0, SIZE_WORD=1'b1;
  - MEM_W;
  - HI_BEAT_OFFSET=2.
- One sub-module, sign_fit_check: combinational, 32-bit in, fits16 out. It is the exact inverse check of the load-path sign extension and is instantiated only under TRUNC_CHECK_EN.

Test Plan:
1. Word store, addr 0x0000_0100, data 0xDEAD_BEEF, ack high -> cycle 1: we=1, 0x100/0xBEEF; cycle 2: we=1, 0x102/0xDEAD; cycle 3: done=1, err=0.
2. Half store, addr 0x200, data 0x0000_4402 -> single beat 0x200/0x4402, done at cycle 2. Repeat with 0xFFFF_8402 -> wdata 0x8402. With TRUNC_CHECK_EN, trunc_err=0 for both; data 0x0001_8402 -> trunc_err=1 and the write still occurs.
3. Word store 0x12345678 with mem_ack low for 3 cycles on each beat -> we/addr/wdata stable throughout; done at cycle 9.
4. Misaligned requests: word at addr 0x102, half at addr 0x201 -> no mem_we ever; done=1 and err=1 in cycle 1; req_ready back high in cycle 2.
5. rst asserted during WR_HI of a word store -> next cycle: IDLE, mem_we=0, done=0, req_ready=1. A following half store then completes normally.
6. Back-to-back requests with req_valid held high -> second accepted in the cycle after FIN; stray mem_ack pulses while in IDLE have no effect.
